mem_responder: RTL and testbench

// - Memory-side responder for the core's data/instruction port: accepts one sized read or write

---
 rtl/mem_responder.sv | 174 +++++++++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : Single-outstanding memory responder with a word-organised RAM,
//            sized byte-lane access and a fixed wait-state count.
// Options  : MEM_RESPONDER_ERR_EN - misaligned accesses fault instead of
//            being force-aligned.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          acc_we;
  logic [AW+1:0] acc_addr;
  logic [1:0]    acc_size;
  logic [31:0]   acc_wdata;
  logic          is_byte, is_half;
  logic [1:0]    off, eff_off;
  logic          acc_err;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic [AW-1:0] idx;
  logic [31:0]   shifted, rd_val;
  logic          enter_resp;
  logic          unused_addr_bits;

  // Upper address bits alias onto the RAM and are deliberately ignored.
  assign unused_addr_bits = ^req_addr_i[31:AW+2];

  // With zero wait states the access completes straight out of IDLE, so the
  // request fields come from the ports rather than the capture registers.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = req_we_i;
      acc_addr  = req_addr_i[AW+1:0];
      acc_size  = req_size_i;
      acc_wdata = req_wdata_i;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_size  = size_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    is_byte = (acc_size == SZ_BYTE);
    is_half = (acc_size == SZ_HALF);
    off     = acc_addr[1:0];
    eff_off = is_byte ? off : (is_half ? {off[1], 1'b0} : 2'b00);
`ifdef MEM_RESPONDER_ERR_EN
    acc_err = (is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00));
`else
    acc_err = 1'b0;
`endif
    be      = is_byte ? (4'b0001 << eff_off) :
              (is_half ? (eff_off[1] ? 4'b1100 : 4'b0011) : 4'b1111);
    wlanes  = is_byte ? {4{acc_wdata[7:0]}} :
              (is_half ? {2{acc_wdata[15:0]}} : acc_wdata);
    idx     = acc_addr[AW+1:2];
    shifted = mem_q[idx] >> {eff_off, 3'b000};
    rd_val  = is_byte ? {24'd0, shifted[7:0]} :
              (is_half ? {16'd0, shifted[15:0]} : shifted);
  end

  assign enter_resp = ((state_q == S_IDLE) && req_valid_i && (WAIT_CYCLES == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == LAST_CNT));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (req_valid_i) state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    rsp_valid_o = (state_q == S_RESP);
    rsp_rdata_o = rdata_q;
    rsp_err_o   = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && req_valid_i) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i[AW+1:0];
        size_q  <= req_size_i;
        wdata_q <= req_wdata_i;
      end
      if (enter_resp) begin
        rdata_q <= (acc_we || acc_err) ? 32'd0 : rd_val;
        err_q   <= acc_err;
      end
    end
  end

  // Storage is not reset; a write caught by reset is dropped.
  always_ff @(posedge clk_i) begin
    if (enter_resp && acc_we && !acc_err && !reset_i) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_q[idx][8*l +: 8] <= wlanes[8*l +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed plus randomized bench for mem_responder against a
//            byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int WAITC = 2;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = 32'd0;
  logic [1:0]  req_size_i = 2'd0;
  logic [31:0] req_wdata_i = 32'd0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_size_i  (req_size_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  refm [DEPTH*4];
  logic [31:0] exp_rd, obs_rd;
  logic        exp_er, obs_er;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: flat little-endian byte array, addresses taken modulo its size.
  task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                       input logic [31:0] wd, input bit apply);
    int nb, a;
    nb = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    a  = int'(addr & 32'(DEPTH*4 - 1));
    exp_rd = 32'd0;
    exp_er = 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
    if ((a % nb) != 0) begin
      exp_er = 1'b1;
      return;
    end
`else
    a = a - (a % nb);
`endif
    for (int i = 0; i < nb; i++) begin
      if (we) begin
        if (apply) refm[a+i] = wd[8*i +: 8];
      end else begin
        exp_rd[8*i +: 8] = refm[a+i];
      end
    end
  endtask

  // Entered at a negedge; returns #1 after the accepting posedge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                       input logic [31:0] wd, input bit apply, input bit keep);
    int g;
    req_we_i    = we;
    req_addr_i  = addr;
    req_size_i  = sz;
    req_wdata_i = wd;
    req_valid_i = 1'b1;
    g = 0;
    while (!req_ready_o && g < 100) begin
      @(negedge clk_i);
      g++;
    end
    chk("accept_timeout", 32'(g < 100), 32'd1);
    @(posedge clk_i);
    model(we, addr, sz, wd, apply);
    #1;
    if (!keep) req_valid_i = 1'b0;
  endtask

  // Waits for the response, holds it for bp cycles, then handshakes it.
  task automatic collect(input int bp);
    int n;
    @(negedge clk_i);
    n = 1;
    while (!rsp_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("latency", n, WAITC + 1);
    for (int k = 0; k < bp; k++) begin
      chk("bp_valid", rsp_valid_o, 1);
      chk("bp_rdata", rsp_rdata_o, exp_rd);
      chk("bp_err", rsp_err_o, exp_er);
      chk("bp_ready", req_ready_o, 0);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b1;
    obs_rd = rsp_rdata_o;
    obs_er = rsp_err_o;
    chk("rsp_valid", rsp_valid_o, 1);
    chk("rsp_rdata", rsp_rdata_o, exp_rd);
    chk("rsp_err", rsp_err_o, exp_er);
    chk("rsp_req_ready", req_ready_o, 0);
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    chk("rst_err", rsp_err_o, 0);

    for (int w = 0; w < DEPTH; w++) begin
      issue(1'b1, 32'(w*4), 2'd2, $urandom, 1'b1, 1'b0);
      collect(0);
    end

    issue(1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 1'b1, 1'b0);
    collect(0);
    issue(1'b0, 32'h10, 2'd2, 32'h0, 1'b1, 1'b0);
    collect(0);
    chk("dir_word_rd", obs_rd, 32'hDEADBEEF);
    chk("dir_word_err", obs_er, 0);

    issue(1'b1, 32'h20, 2'd2, 32'h11223344, 1'b1, 1'b0);
    collect(1);
    issue(1'b1, 32'h22, 2'd0, 32'hFFFFFFAA, 1'b1, 1'b0);
    collect(0);
    issue(1'b0, 32'h20, 2'd2, 32'h0, 1'b1, 1'b0);
    collect(0);
    chk("dir_merge_word", obs_rd, 32'h11AA3344);
    issue(1'b0, 32'h22, 2'd1, 32'h0, 1'b1, 1'b0);
    collect(0);
    chk("dir_merge_half", obs_rd, 32'h000011AA);

    // Second request held valid across a stalled response.
    issue(1'b0, 32'h20, 2'd2, 32'h0, 1'b1, 1'b1);
    req_we_i   = 1'b0;
    req_addr_i = 32'h23;
    req_size_i = 2'd0;
    collect(5);
    chk("dir_bp_first", obs_rd, 32'h11AA3344);
    chk("bp_idle_ready", req_ready_o, 1);
    chk("bp_idle_valid", rsp_valid_o, 0);
    issue(1'b0, 32'h23, 2'd0, 32'h0, 1'b1, 1'b0);
    collect(0);
    chk("dir_bp_second", obs_rd, 32'h00000011);

    issue(1'b1, 32'h30, 2'd2, 32'hCAFEF00D, 1'b1, 1'b0);
    collect(0);
    issue(1'b1, 32'h31, 2'd2, 32'h12345678, 1'b1, 1'b0);
    collect(0);
`ifdef MEM_RESPONDER_ERR_EN
    chk("dir_mis_err", obs_er, 1);
`else
    chk("dir_mis_err", obs_er, 0);
`endif
    chk("dir_mis_rdata", obs_rd, 0);
    issue(1'b0, 32'h30, 2'd2, 32'h0, 1'b1, 1'b0);
    collect(0);
`ifdef MEM_RESPONDER_ERR_EN
    chk("dir_mis_after", obs_rd, 32'hCAFEF00D);
`else
    chk("dir_mis_after", obs_rd, 32'h12345678);
`endif

    issue(1'b1, 32'h40, 2'd2, 32'h55667788, 1'b1, 1'b0);
    collect(0);
    issue(1'b1, 32'h40, 2'd2, 32'h99999999, 1'b0, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_req_ready", req_ready_o, 1);
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    chk("midrst_rdata", rsp_rdata_o, 0);
    chk("midrst_err", rsp_err_o, 0);
    issue(1'b0, 32'(DEPTH*4 + 32'h40), 2'd2, 32'h0, 1'b1, 1'b0);
    collect(0);
    chk("dir_alias_rd", obs_rd, 32'h55667788);

    for (int t = 0; t < 200; t++) begin
      issue(1'($urandom), $urandom, 2'($urandom), $urandom, 1'b1, 1'b0);
      collect(int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

endmodule

`default_nettype wire
